pixel_compositor: RTL and testbench

//   Pipelined, parametrised pixel colour generator for the VGA path. Draws the
//   two piano keyboards, guide lines and floor band, then overlays NUM_LAYERS

---
 rtl/pixel_compositor_if.sv | 31 +++
 rtl/pixel_compositor.sv | 158 +++++++++++++++
 tb/tb_pixel_compositor.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/pixel_compositor_if.sv
// Pixel bus between the VGA timing counter / glyph sources and the compositor.
// master drives the pixel request, slave (the compositor) returns colour and frame tick.
interface pixel_compositor_if #(
  parameter int NUM_LAYERS = 4,
  parameter int NUM_KEYS   = 14
);
  logic                        bright;
  logic [9:0]                  hCount;
  logic [9:0]                  vCount;
  logic [7:0]                  backgroundColor;
  logic [NUM_LAYERS-1:0]       layerValid;
  logic [8*NUM_LAYERS-1:0]     layerRgb;
  logic                        hitValid;
  logic                        hitSide;
  logic [$clog2(NUM_KEYS)-1:0] hitKey;
  logic [7:0]                  rgb;
  logic                        brightOut;
  logic                        frameTick;

  modport master (
    output bright, hCount, vCount, backgroundColor, layerValid, layerRgb,
           hitValid, hitSide, hitKey,
    input  rgb, brightOut, frameTick
  );

  modport slave (
    input  bright, hCount, vCount, backgroundColor, layerValid, layerRgb,
           hitValid, hitSide, hitKey,
    output rgb, brightOut, frameTick
  );
endinterface

// File: rtl/pixel_compositor.sv
// Two-stage pixel colour pipeline: keyboards, guide lines, floor band, glyph
// layers and per-side key-hit flash, aligned with a delayed bright flag.
module pixel_compositor #(
  parameter int                     NUM_LAYERS   = 4,
  parameter int                     NUM_KEYS     = 14,
  parameter int                     KEY_PITCH    = 30,
  parameter int                     KEY_W        = 65,
  parameter int                     BLACK_W      = 45,
  parameter logic [NUM_KEYS-1:0]    BLACK_MASK   = 14'h376E,
  parameter int                     FLASH_FRAMES = 8,
  parameter logic [7:0]             HIT_COLOR    = 8'h1C
) (
  input logic               pixelClk,
  input logic               reset,
  pixel_compositor_if.slave bus
);

  localparam int KW = $clog2(NUM_KEYS);
  localparam int CW = (FLASH_FRAMES < 1) ? 1 : $clog2(FLASH_FRAMES + 1);

  localparam logic [9:0]    KP         = 10'(KEY_PITCH);
  localparam logic [9:0]    KB_H       = 10'(NUM_KEYS * KEY_PITCH);
  localparam logic [9:0]    LEFT_X     = 10'(KEY_W);
  localparam logic [9:0]    RIGHT_X    = 10'(640 - KEY_W);
  localparam logic [9:0]    BLK_L      = 10'(BLACK_W);
  localparam logic [9:0]    BLK_R      = 10'(640 - BLACK_W);
  localparam logic [9:0]    HALF_BLK   = 10'd7;
  localparam logic [9:0]    NK         = 10'(NUM_KEYS);
  localparam logic [9:0]    GUIDE_L    = 10'd95;
  localparam logic [9:0]    GUIDE_R    = 10'd545;
  localparam logic [9:0]    BAND_LO    = 10'd454;
  localparam logic [9:0]    BAND_HI    = 10'd455;
  localparam logic [CW-1:0] FLASH_LOAD = CW'(FLASH_FRAMES);

  typedef enum logic [2:0] {
    REG_BG, REG_WHITE, REG_FLASH, REG_BLACK, REG_GUIDE, REG_BELOW, REG_BAND
  } region_e;

  region_e               region_q, region_d;
  logic [7:0]            bg_q, bg_d;
  logic                  layer_hit_q, layer_hit_d;
  logic [7:0]            layer_rgb_q, layer_rgb_d;
  logic                  bright1_q, bright1_d;
  logic                  origin_q, origin_d;
  logic                  frame_tick_q, frame_tick_d;
  logic [7:0]            rgb_q, rgb_d;
  logic                  bright_out_q, bright_out_d;
  logic [1:0][CW-1:0]    flash_cnt_q, flash_cnt_d;
  logic [1:0][KW-1:0]    flash_key_q, flash_key_d;

  logic [9:0] key_idx, key_rem, boundary;
  logic       side, on_kb, in_black_x, black_span, flash_on;

  // Stage 1: classify the pixel and pick the winning glyph layer.
  always_comb begin
    key_idx    = bus.vCount / KP;
    key_rem    = bus.vCount % KP;
    boundary   = (key_rem <= HALF_BLK) ? key_idx : key_idx + 10'd1;
    black_span = ((key_rem <= HALF_BLK) || (key_rem >= KP - HALF_BLK)) &&
                 (boundary < NK) && BLACK_MASK[boundary[KW-1:0]];
    side       = (bus.hCount >= RIGHT_X);
    on_kb      = ((bus.hCount <= LEFT_X) || side) && (bus.vCount < KB_H);
    in_black_x = side ? (bus.hCount >= BLK_R) : (bus.hCount < BLK_L);
    flash_on   = (flash_cnt_q[side] != '0) && (key_idx[KW-1:0] == flash_key_q[side]);

    region_d = REG_BG;
    if (on_kb) begin
      if ((key_rem == 10'd0) || (bus.hCount == LEFT_X) || (bus.hCount == RIGHT_X) ||
          (in_black_x && black_span))
        region_d = REG_BLACK;
      else if (flash_on)
        region_d = REG_FLASH;
      else
        region_d = REG_WHITE;
    end
    if ((bus.hCount == GUIDE_L) || (bus.hCount == GUIDE_R)) region_d = REG_GUIDE;
    if (bus.vCount >= KB_H) region_d = REG_BELOW;
    if ((bus.vCount >= BAND_LO) && (bus.vCount <= BAND_HI)) region_d = REG_BAND;

    layer_hit_d = 1'b0;
    layer_rgb_d = 8'h00;
    for (int i = 0; i < NUM_LAYERS; i++) begin
      if (bus.layerValid[i]) begin
        layer_hit_d = 1'b1;
        layer_rgb_d = bus.layerRgb[8*i +: 8];
      end
    end

    bg_d         = bus.backgroundColor;
    bright1_d    = bus.bright;
    origin_d     = (bus.hCount == 10'd0) && (bus.vCount == 10'd0);
    frame_tick_d = origin_d && !origin_q;
  end

  // A valid hit reloads its side; the frame tick ages both sides otherwise.
  always_comb begin
    flash_cnt_d = flash_cnt_q;
    flash_key_d = flash_key_q;
    for (int s = 0; s < 2; s++) begin
      if (frame_tick_q && (flash_cnt_q[s] != '0))
        flash_cnt_d[s] = flash_cnt_q[s] - CW'(1);
    end
    if (bus.hitValid && ({{(10-KW){1'b0}}, bus.hitKey} < NK)) begin
      flash_cnt_d[bus.hitSide] = FLASH_LOAD;
      flash_key_d[bus.hitSide] = bus.hitKey;
    end
  end

  // Stage 2: resolve the final colour; bright low blanks everything.
  always_comb begin
    case (region_q)
      REG_BG:    rgb_d = bg_q;
      REG_WHITE: rgb_d = 8'hFF;
      REG_FLASH: rgb_d = HIT_COLOR;
      REG_BLACK: rgb_d = 8'h00;
      REG_GUIDE: rgb_d = 8'hE0;
      REG_BELOW: rgb_d = 8'h00;
      REG_BAND:  rgb_d = 8'hFF;
      default:   rgb_d = 8'h00;
    endcase
    if (layer_hit_q) rgb_d = layer_rgb_q;
    if (!bright1_q)  rgb_d = 8'h00;
    bright_out_d = bright1_q;
  end

  always_ff @(posedge pixelClk or posedge reset) begin
    if (reset) begin
      region_q     <= REG_BG;
      bg_q         <= 8'h00;
      layer_hit_q  <= 1'b0;
      layer_rgb_q  <= 8'h00;
      bright1_q    <= 1'b0;
      origin_q     <= 1'b0;
      frame_tick_q <= 1'b0;
      rgb_q        <= 8'h00;
      bright_out_q <= 1'b0;
      flash_cnt_q  <= '0;
      flash_key_q  <= '0;
    end else begin
      region_q     <= region_d;
      bg_q         <= bg_d;
      layer_hit_q  <= layer_hit_d;
      layer_rgb_q  <= layer_rgb_d;
      bright1_q    <= bright1_d;
      origin_q     <= origin_d;
      frame_tick_q <= frame_tick_d;
      rgb_q        <= rgb_d;
      bright_out_q <= bright_out_d;
      flash_cnt_q  <= flash_cnt_d;
      flash_key_q  <= flash_key_d;
    end
  end

  assign bus.rgb       = rgb_q;
  assign bus.brightOut = bright_out_q;
  assign bus.frameTick = frame_tick_q;

endmodule

// File: tb/tb_pixel_compositor.sv
// Directed bench for pixel_compositor: expected colours are queued at stimulus
// time and popped by a monitor two cycles later when the pixel emerges.
module tb_pixel_compositor;

  logic pixelClk = 1'b0;
  logic reset    = 1'b1;

  always #5 pixelClk = ~pixelClk;

  pixel_compositor_if #(.NUM_LAYERS(4), .NUM_KEYS(14)) bus ();

  pixel_compositor dut (
    .pixelClk (pixelClk),
    .reset    (reset),
    .bus      (bus)
  );

  typedef struct {
    logic [7:0] rgb;
    logic       bright;
    int         id;
  } exp_t;

  exp_t exp_q[$];
  int   checks     = 0;
  int   errors     = 0;
  int   next_id    = 0;
  int   tick_count = 0;
  int   tick_base  = 0;
  logic mark       = 1'b0;
  logic mark_d1    = 1'b0;
  logic mark_d2    = 1'b0;

  logic        cur_bright = 1'b1;
  logic [7:0]  cur_bg     = 8'h00;
  logic [3:0]  cur_lv     = 4'h0;
  logic [31:0] cur_lr     = 32'h0;

  task automatic checkOutput(input string name, input int id,
                             input logic [7:0] got, input logic [7:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s #%0d: got %02h, want %02h", name, id, got, want);
    end
  endtask

  // Drive one pixel for one cycle; optionally queue its expected colour.
  task automatic applyStimulus(input logic [9:0] h, input logic [9:0] v,
                               input logic hv, input logic hs, input logic [3:0] hk,
                               input logic chk, input logic [7:0] want);
    @(negedge pixelClk);
    bus.hCount          = h;
    bus.vCount          = v;
    bus.bright          = cur_bright;
    bus.backgroundColor = cur_bg;
    bus.layerValid      = cur_lv;
    bus.layerRgb        = cur_lr;
    bus.hitValid        = hv;
    bus.hitSide         = hs;
    bus.hitKey          = hk;
    mark                = chk;
    if (chk) begin
      exp_q.push_back(exp_t'{rgb: want, bright: cur_bright, id: next_id});
      next_id++;
    end
  endtask

  always @(posedge pixelClk) begin
    mark_d1 <= mark;
    mark_d2 <= mark_d1;
  end

  // Monitor: a marked pixel is due on rgb two edges after it was sampled.
  always @(negedge pixelClk) begin
    exp_t e;
    if (bus.frameTick) tick_count++;
    if (mark_d2) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_output: got %02h, want nothing queued", bus.rgb);
      end else begin
        e = exp_q.pop_front();
        checkOutput("rgb", e.id, bus.rgb, e.rgb);
        checkOutput("brightOut", e.id, {7'd0, bus.brightOut}, {7'd0, e.bright});
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation did not finish, want finish before 200000");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    bus.hCount = '0; bus.vCount = '0; bus.bright = 1'b0; bus.backgroundColor = '0;
    bus.layerValid = '0; bus.layerRgb = '0; bus.hitValid = 1'b0; bus.hitSide = 1'b0;
    bus.hitKey = '0;

    repeat (3) @(negedge pixelClk);
    checkOutput("reset_rgb_init", 0, bus.rgb, 8'h00);
    reset = 1'b0;

    // Reset asserted mid-line clears the outputs at once.
    repeat (3) applyStimulus(10'd10, 10'd15, 1'b0, 1'b0, 4'd0, 1'b0, 8'h00);
    @(posedge pixelClk); #1;
    checkOutput("pre_reset_rgb", 0, bus.rgb, 8'hFF);
    #2 reset = 1'b1;
    #1;
    checkOutput("reset_rgb", 0, bus.rgb, 8'h00);
    checkOutput("reset_brightOut", 0, {7'd0, bus.brightOut}, 8'h00);
    checkOutput("reset_frameTick", 0, {7'd0, bus.frameTick}, 8'h00);
    repeat (2) @(negedge pixelClk);
    reset = 1'b0;
    @(posedge pixelClk); #1;
    checkOutput("release_stage1_rgb", 0, bus.rgb, 8'h00);
    @(posedge pixelClk); #1;
    checkOutput("release_first_rgb", 0, bus.rgb, 8'hFF);

    // Static colour rules.
    cur_bg = 8'h03;
    applyStimulus(10'd10,  10'd15,  1'b0, 1'b0, 4'd0, 1'b1, 8'hFF);
    applyStimulus(10'd10,  10'd30,  1'b0, 1'b0, 4'd0, 1'b1, 8'h00);
    applyStimulus(10'd10,  10'd25,  1'b0, 1'b0, 4'd0, 1'b1, 8'h00);
    applyStimulus(10'd300, 10'd200, 1'b0, 1'b0, 4'd0, 1'b1, 8'h03);
    cur_lv = 4'b0101; cur_lr = 32'h0055_00AA;
    applyStimulus(10'd300, 10'd200, 1'b0, 1'b0, 4'd0, 1'b1, 8'h55);
    cur_lv = 4'b0001;
    applyStimulus(10'd300, 10'd200, 1'b0, 1'b0, 4'd0, 1'b1, 8'hAA);
    cur_lv = 4'b0000; cur_lr = 32'h0;
    applyStimulus(10'd95,  10'd200, 1'b0, 1'b0, 4'd0, 1'b1, 8'hE0);
    cur_bright = 1'b0;
    applyStimulus(10'd95,  10'd200, 1'b0, 1'b0, 4'd0, 1'b1, 8'h00);
    cur_bright = 1'b1;
    applyStimulus(10'd95,  10'd455, 1'b0, 1'b0, 4'd0, 1'b1, 8'hFF);
    applyStimulus(10'd95,  10'd430, 1'b0, 1'b0, 4'd0, 1'b1, 8'h00);
    applyStimulus(10'd300, 10'd454, 1'b0, 1'b0, 4'd0, 1'b1, 8'hFF);
    applyStimulus(10'd600, 10'd15,  1'b0, 1'b0, 4'd0, 1'b1, 8'hFF);
    applyStimulus(10'd620, 10'd25,  1'b0, 1'b0, 4'd0, 1'b1, 8'h00);
    applyStimulus(10'd575, 10'd100, 1'b0, 1'b0, 4'd0, 1'b1, 8'h00);
    applyStimulus(10'd65,  10'd100, 1'b0, 1'b0, 4'd0, 1'b1, 8'h00);
    applyStimulus(10'd66,  10'd100, 1'b0, 1'b0, 4'd0, 1'b1, 8'h03);
    applyStimulus(10'd10,  10'd88,  1'b0, 1'b0, 4'd0, 1'b1, 8'h00);
    applyStimulus(10'd10,  10'd113, 1'b0, 1'b0, 4'd0, 1'b1, 8'hFF);
    cur_lv = 4'b1000; cur_lr = 32'h1200_0000;
    applyStimulus(10'd95,  10'd455, 1'b0, 1'b0, 4'd0, 1'b1, 8'h12);
    cur_bright = 1'b0;
    applyStimulus(10'd95,  10'd455, 1'b0, 1'b0, 4'd0, 1'b1, 8'h00);
    cur_bright = 1'b1; cur_lv = 4'b0000; cur_lr = 32'h0;

    // Holding the counter at the origin produces a single frame tick.
    applyStimulus(10'd5, 10'd5, 1'b0, 1'b0, 4'd0, 1'b0, 8'h00);
    tick_base = tick_count;
    repeat (4) applyStimulus(10'd0, 10'd0, 1'b0, 1'b0, 4'd0, 1'b0, 8'h00);
    repeat (4) applyStimulus(10'd1, 10'd0, 1'b0, 1'b0, 4'd0, 1'b0, 8'h00);
    checkOutput("frame_tick_count", 0, 8'(tick_count - tick_base), 8'd1);

    // Left key 3 flashes for 8 frames then returns to white.
    applyStimulus(10'd1, 10'd0, 1'b1, 1'b0, 4'd3, 1'b0, 8'h00);
    for (int f = 1; f <= 9; f++) begin
      applyStimulus(10'd50, 10'd100, 1'b0, 1'b0, 4'd0, 1'b1, (f <= 8) ? 8'h1C : 8'hFF);
      if (f == 1) begin
        applyStimulus(10'd50,  10'd130, 1'b0, 1'b0, 4'd0, 1'b1, 8'hFF);
        applyStimulus(10'd50,  10'd90,  1'b0, 1'b0, 4'd0, 1'b1, 8'h00);
        applyStimulus(10'd580, 10'd100, 1'b0, 1'b0, 4'd0, 1'b1, 8'hFF);
      end
      applyStimulus(10'd0, 10'd0, 1'b0, 1'b0, 4'd0, 1'b0, 8'h00);
      applyStimulus(10'd1, 10'd0, 1'b0, 1'b0, 4'd0, 1'b0, 8'h00);
      applyStimulus(10'd2, 10'd0, 1'b0, 1'b0, 4'd0, 1'b0, 8'h00);
    end

    // An out-of-range key must not replace the active flash.
    applyStimulus(10'd1, 10'd0, 1'b1, 1'b0, 4'd3,  1'b0, 8'h00);
    applyStimulus(10'd2, 10'd0, 1'b1, 1'b0, 4'd14, 1'b0, 8'h00);
    applyStimulus(10'd50, 10'd100, 1'b0, 1'b0, 4'd0, 1'b1, 8'h1C);

    // Right key 0 armed, then left reloaded on the very cycle frameTick is high.
    applyStimulus(10'd3, 10'd0, 1'b1, 1'b1, 4'd0, 1'b0, 8'h00);
    applyStimulus(10'd0, 10'd0, 1'b0, 1'b0, 4'd0, 1'b0, 8'h00);
    applyStimulus(10'd1, 10'd0, 1'b1, 1'b0, 4'd3, 1'b0, 8'h00);
    for (int f = 1; f <= 9; f++) begin
      applyStimulus(10'd50,  10'd100, 1'b0, 1'b0, 4'd0, 1'b1, (f <= 8) ? 8'h1C : 8'hFF);
      applyStimulus(10'd580, 10'd15,  1'b0, 1'b0, 4'd0, 1'b1, (f <= 7) ? 8'h1C : 8'hFF);
      applyStimulus(10'd0, 10'd0, 1'b0, 1'b0, 4'd0, 1'b0, 8'h00);
      applyStimulus(10'd1, 10'd0, 1'b0, 1'b0, 4'd0, 1'b0, 8'h00);
    end

    repeat (4) applyStimulus(10'd1, 10'd0, 1'b0, 1'b0, 4'd0, 1'b0, 8'h00);
    checkOutput("scoreboard_drain", 0, 8'(exp_q.size()), 8'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
